// File: rtl/unidad_control.sv
// Single-cycle RISC-V main control decoder with all outputs registered on CLK.
// Decode is purely combinational; one register stage gives exactly one cycle of latency.
module unidad_control (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       comp,
  output logic       WE_Data,
  output logic       RE_Data,
  output logic       BYTE_STR,
  output logic       BYTE_LDR,
  output logic [2:0] IMM_SRC,
  output logic       WE_Regs,
  output logic [2:0] ALU_OP,
  output logic       JALR,
  output logic       PC_SRC,
  output logic [1:0] RS1_SRC,
  output logic       OP1_SRC,
  output logic       OP2_SRC,
  output logic [1:0] WRITE_SRC
);

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b010;

  typedef struct packed {
    logic       we_data;
    logic       re_data;
    logic       byte_str;
    logic       byte_ldr;
    logic [2:0] imm_src;
    logic       we_regs;
    logic [2:0] alu_op;
    logic       jalr;
    logic       pc_src;
    logic [1:0] rs1_src;
    logic       op1_src;
    logic       op2_src;
    logic [1:0] write_src;
  } ctrl_t;

  ctrl_t      ctrl_d, ctrl_q;
  logic [2:0] alu_f3;

  // funct3 -> ALU_OP; SLTU (011) shares the SLT encoding
  always_comb begin
    alu_f3 = ALU_ADD;
    unique case (funct3)
      3'b000: alu_f3 = 3'b000;
      3'b001: alu_f3 = 3'b001;
      3'b010: alu_f3 = 3'b011;
      3'b011: alu_f3 = 3'b011;
      3'b100: alu_f3 = 3'b100;
      3'b101: alu_f3 = 3'b101;
      3'b110: alu_f3 = 3'b110;
      3'b111: alu_f3 = 3'b111;
      default: alu_f3 = ALU_ADD;
    endcase
  end

  always_comb begin
    ctrl_d = '0;
    case (opcode)
      OPC_R: begin
        ctrl_d.we_regs   = 1'b1;
        ctrl_d.op1_src   = 1'b1;
        ctrl_d.write_src = 2'b01;
        ctrl_d.alu_op    = (funct3 == 3'b000 && funct7) ? ALU_SUB : alu_f3;
      end
      OPC_I_ALU: begin
        ctrl_d.we_regs   = 1'b1;
        ctrl_d.write_src = 2'b01;
        ctrl_d.alu_op    = alu_f3;
      end
      OPC_LOAD: begin
        ctrl_d.re_data   = 1'b1;
        ctrl_d.we_regs   = 1'b1;
        ctrl_d.byte_ldr  = (funct3 == 3'b000) || (funct3 == 3'b100);
      end
      OPC_STORE: begin
        ctrl_d.we_data   = 1'b1;
        ctrl_d.imm_src   = 3'b001;
        ctrl_d.byte_str  = (funct3 == 3'b000);
      end
      OPC_BRANCH: begin
        ctrl_d.imm_src   = 3'b010;
        ctrl_d.op1_src   = 1'b1;
        ctrl_d.alu_op    = ALU_SUB;
        ctrl_d.pc_src    = comp;
      end
      OPC_JAL: begin
        ctrl_d.imm_src   = 3'b100;
        ctrl_d.pc_src    = 1'b1;
        ctrl_d.we_regs   = 1'b1;
        ctrl_d.write_src = 2'b10;
        ctrl_d.rs1_src   = 2'b01;
      end
      OPC_JALR: begin
        ctrl_d.jalr      = 1'b1;
        ctrl_d.pc_src    = 1'b1;
        ctrl_d.we_regs   = 1'b1;
        ctrl_d.write_src = 2'b10;
      end
      OPC_LUI: begin
        ctrl_d.imm_src   = 3'b011;
        ctrl_d.we_regs   = 1'b1;
        ctrl_d.write_src = 2'b11;
        ctrl_d.rs1_src   = 2'b01;
      end
      OPC_AUIPC: begin
        ctrl_d.imm_src   = 3'b011;
        ctrl_d.op2_src   = 1'b1;
        ctrl_d.we_regs   = 1'b1;
        ctrl_d.write_src = 2'b01;
      end
      default: ctrl_d = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) ctrl_q <= '0;
    else      ctrl_q <= ctrl_d;
  end

  assign WE_Data   = ctrl_q.we_data;
  assign RE_Data   = ctrl_q.re_data;
  assign BYTE_STR  = ctrl_q.byte_str;
  assign BYTE_LDR  = ctrl_q.byte_ldr;
  assign IMM_SRC   = ctrl_q.imm_src;
  assign WE_Regs   = ctrl_q.we_regs;
  assign ALU_OP    = ctrl_q.alu_op;
  assign JALR      = ctrl_q.jalr;
  assign PC_SRC    = ctrl_q.pc_src;
  assign RS1_SRC   = ctrl_q.rs1_src;
  assign OP1_SRC   = ctrl_q.op1_src;
  assign OP2_SRC   = ctrl_q.op2_src;
  assign WRITE_SRC = ctrl_q.write_src;

endmodule

// File: tb/tb_unidad_control.sv
// Scoreboard bench for unidad_control: expectations queued at drive time, checked one edge later.
module tb_unidad_control;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       funct7 = 1'b0;
  logic       comp = 1'b0;
  logic       WE_Data, RE_Data, BYTE_STR, BYTE_LDR, WE_Regs, JALR, PC_SRC, OP1_SRC, OP2_SRC;
  logic [2:0] IMM_SRC, ALU_OP;
  logic [1:0] RS1_SRC, WRITE_SRC;

  int unsigned checks = 0;
  int unsigned failures = 0;

  logic [18:0] exp_q[$];
  string       name_q[$];

  unidad_control dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .funct3(funct3), .funct7(funct7), .comp(comp),
    .WE_Data(WE_Data), .RE_Data(RE_Data), .BYTE_STR(BYTE_STR), .BYTE_LDR(BYTE_LDR),
    .IMM_SRC(IMM_SRC), .WE_Regs(WE_Regs), .ALU_OP(ALU_OP), .JALR(JALR), .PC_SRC(PC_SRC),
    .RS1_SRC(RS1_SRC), .OP1_SRC(OP1_SRC), .OP2_SRC(OP2_SRC), .WRITE_SRC(WRITE_SRC)
  );

  always #5 CLK = ~CLK;

  function automatic logic [18:0] actual();
    return {WE_Data, RE_Data, BYTE_STR, BYTE_LDR, IMM_SRC, WE_Regs, ALU_OP, JALR, PC_SRC,
            RS1_SRC, OP1_SRC, OP2_SRC, WRITE_SRC};
  endfunction

  function automatic logic [18:0] mk(logic wd, logic rd, logic bs, logic bl, logic [2:0] imm,
                                     logic wr, logic [2:0] alu, logic jr, logic pc,
                                     logic [1:0] rs1, logic o1, logic o2, logic [1:0] ws);
    return {wd, rd, bs, bl, imm, wr, alu, jr, pc, rs1, o1, o2, ws};
  endfunction

  // Reference decode written from the instruction-class table
  function automatic logic [18:0] model(logic [6:0] op, logic [2:0] f3, logic f7, logic c);
    logic [2:0] a;
    case (f3)
      3'd2, 3'd3: a = 3'd3;
      default:    a = f3;
    endcase
    case (op)
      7'b0110011: return mk(0,0,0,0,3'd0,1,(f3 == 3'd0 && f7) ? 3'd2 : a,0,0,2'd0,1,0,2'd1);
      7'b0010011: return mk(0,0,0,0,3'd0,1,a,0,0,2'd0,0,0,2'd1);
      7'b0000011: return mk(0,1,0,(f3 == 3'd0 || f3 == 3'd4),3'd0,1,3'd0,0,0,2'd0,0,0,2'd0);
      7'b0100011: return mk(1,0,(f3 == 3'd0),0,3'd1,0,3'd0,0,0,2'd0,0,0,2'd0);
      7'b1100011: return mk(0,0,0,0,3'd2,0,3'd2,0,c,2'd0,1,0,2'd0);
      7'b1101111: return mk(0,0,0,0,3'd4,1,3'd0,0,1,2'd1,0,0,2'd2);
      7'b1100111: return mk(0,0,0,0,3'd0,1,3'd0,1,1,2'd0,0,0,2'd2);
      7'b0110111: return mk(0,0,0,0,3'd3,1,3'd0,0,0,2'd1,0,0,2'd3);
      7'b0010111: return mk(0,0,0,0,3'd3,1,3'd0,0,0,2'd0,0,1,2'd1);
      default:    return '0;
    endcase
  endfunction

  task automatic issue(input string nm, input logic [6:0] op, input logic [2:0] f3,
                       input logic f7, input logic c, input logic [18:0] e);
    @(negedge CLK);
    opcode = op; funct3 = f3; funct7 = f7; comp = c;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic test_reset();
    logic [18:0] a;
    RST = 1'b0;
    opcode = 7'b1101111; funct3 = 3'd5; funct7 = 1'b1; comp = 1'b1;
    #2;
    a = actual();
    checks++;
    if (a !== 19'd0) begin
      failures++;
      $display("FAIL reset_no_clock actual=%h expected=%h", a, 19'd0);
    end
    repeat (2) @(posedge CLK);
    #1;
    a = actual();
    checks++;
    if (a !== 19'd0) begin
      failures++;
      $display("FAIL reset_held actual=%h expected=%h", a, 19'd0);
    end
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    a = actual();
    checks++;
    if (a !== mk(0,0,0,0,3'd4,1,3'd0,0,1,2'd1,0,0,2'd2)) begin
      failures++;
      $display("FAIL reset_release_jal actual=%h expected=%h", a,
               mk(0,0,0,0,3'd4,1,3'd0,0,1,2'd1,0,0,2'd2));
    end
  endtask

  task automatic test_directed();
    logic [18:0] e, a;
    string nm;
    exp_q.delete(); name_q.delete();
    for (int i = 0; i < 12; i++) begin
      case (i)
        0:  issue("add",   7'b0110011, 3'd0, 0, 0, mk(0,0,0,0,3'd0,1,3'd0,0,0,2'd0,1,0,2'd1));
        1:  issue("sub",   7'b0110011, 3'd0, 1, 0, mk(0,0,0,0,3'd0,1,3'd2,0,0,2'd0,1,0,2'd1));
        2:  issue("xori",  7'b0010011, 3'd4, 1, 1, mk(0,0,0,0,3'd0,1,3'd4,0,0,2'd0,0,0,2'd1));
        3:  issue("beq_c0",7'b1100011, 3'd0, 0, 0, mk(0,0,0,0,3'd2,0,3'd2,0,0,2'd0,1,0,2'd0));
        4:  issue("beq_c1",7'b1100011, 3'd0, 0, 1, mk(0,0,0,0,3'd2,0,3'd2,0,1,2'd0,1,0,2'd0));
        5:  issue("lb",    7'b0000011, 3'd0, 0, 0, mk(0,1,0,1,3'd0,1,3'd0,0,0,2'd0,0,0,2'd0));
        6:  issue("sw",    7'b0100011, 3'd2, 0, 0, mk(1,0,0,0,3'd1,0,3'd0,0,0,2'd0,0,0,2'd0));
        7:  issue("jalr",  7'b1100111, 3'd0, 0, 1, mk(0,0,0,0,3'd0,1,3'd0,1,1,2'd0,0,0,2'd2));
        8:  issue("lui",   7'b0110111, 3'd3, 0, 1, mk(0,0,0,0,3'd3,1,3'd0,0,0,2'd1,0,0,2'd3));
        9:  issue("auipc", 7'b0010111, 3'd7, 1, 0, mk(0,0,0,0,3'd3,1,3'd0,0,0,2'd0,0,1,2'd1));
        10: issue("addi_f7",7'b0010011,3'd0, 1, 0, mk(0,0,0,0,3'd0,1,3'd0,0,0,2'd0,0,0,2'd1));
        default: issue("zero_op",7'b0000000,3'd0,1,1, 19'd0);
      endcase
      @(posedge CLK);
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL directed_queue_empty index=%0d", i);
      end else begin
        e = exp_q.pop_front();
        nm = name_q.pop_front();
        a = actual();
        if (a !== e) begin
          failures++;
          $display("FAIL %s actual=%h expected=%h", nm, a, e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [18:0] e, a;
    string nm;
    logic [6:0] ops [10];
    logic [6:0] op;
    logic [2:0] f3;
    logic f7, c;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};
    exp_q.delete(); name_q.delete();
    for (int i = 0; i < 200; i++) begin
      op = (i % 17 == 16) ? 7'($urandom) : ops[$urandom_range(0, 9)];
      f3 = 3'($urandom); f7 = 1'($urandom); c = 1'($urandom);
      issue("random", op, f3, f7, c, model(op, f3, f7, c));
      @(posedge CLK);
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL b2b_queue_empty index=%0d", i);
      end else begin
        e = exp_q.pop_front();
        nm = name_q.pop_front();
        a = actual();
        if (a !== e) begin
          failures++;
          $display("FAIL %s op=%b f3=%b f7=%b c=%b actual=%h expected=%h", nm, op, f3, f7, c, a, e);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [18:0] a;
    issue("pre_lui", 7'b0110111, 3'd0, 0, 0, mk(0,0,0,0,3'd3,1,3'd0,0,0,2'd1,0,0,2'd3));
    @(posedge CLK);
    #1;
    a = actual();
    checks++;
    if (a !== exp_q.pop_front()) begin
      failures++;
      $display("FAIL pre_mid_reset actual=%h expected=%h", a,
               mk(0,0,0,0,3'd3,1,3'd0,0,0,2'd1,0,0,2'd3));
    end
    void'(name_q.pop_front());
    RST = 1'b0;
    #1;
    a = actual();
    checks++;
    if (a !== 19'd0) begin
      failures++;
      $display("FAIL mid_reset_async actual=%h expected=%h", a, 19'd0);
    end
    @(negedge CLK);
    RST = 1'b1;
    opcode = 7'b0000011; funct3 = 3'd4;
    @(posedge CLK);
    #1;
    a = actual();
    checks++;
    if (a !== mk(0,1,0,1,3'd0,1,3'd0,0,0,2'd0,0,0,2'd0)) begin
      failures++;
      $display("FAIL post_reset_lbu actual=%h expected=%h", a,
               mk(0,1,0,1,3'd0,1,3'd0,0,0,2'd0,0,0,2'd0));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
